bf16_vec_minmax_stream: RTL and testbench
=========================================

Name: bf16_vec_minmax_stream

Overview:
- N-lane BFloat16 streaming min/max unit with a valid/ready handshake on both input and output.
- Supports two kinds of operation:
  - per-beat elementwise MIN/MAX of two vectors;
  - per-lane running MIN/MAX reduction across a multi-beat packet, delimited by in_last, which also reports the winning beat index.
- Sits beside the vector MAC/divider/comparator units behind the unit-level mode mux, and serves as the reduction engine for softmax/argmax-style post-processing.

Parameters:
- N, 2, number of 16-bit BF16 lanes.
- IDX_W, 8, width of the per-lane beat index and beat counter.

Ports:
- clk1  in  1  clock, rising edge
- rst1  in  1  reset, asynchronous, active-high
- a1  in  16*N  operand A; lane i = a1[16*i+15:16*i]
- b1  in  16*N  operand B; used only in elementwise modes
- control  in  2  00 elem MIN, 01 elem MAX, 10 reduce MAX, 11 reduce MIN
- in_valid  in  1  input beat valid
- in_last  in  1  last beat of a packet; ignored in elementwise modes
- in_ready  out  1  input beat accepted when in_valid && in_ready
- out  out  16*N  result vector
- out_idx  out  IDX_W*N  per-lane winning beat index (reduce modes); 0 in elementwise modes
- out_nan  out  N  per-lane flag: a NaN was seen in the result's inputs
- out_ovf  out  1  packet length exceeded 2^IDX_W beats
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- busy  out  1  a reduce packet is open (state RUN)

Behaviour:
- Reset (async, rst1=1):
  - out, out_idx, out_nan, out_ovf, out_valid and busy all go to 0.
  - FSM goes to IDLE; accumulators and beat counter clear.
  - Reset mid-packet discards the partial reduction; no output is produced.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register, no bubble under continuous ready).
  - Once out_valid rises, out, out_idx, out_nan and out_ovf hold stable until the out handshake completes.
- Ordering key (per lane, non-NaN):
  - key = x[15] ? ~x : x | 16'h8000, compared as unsigned.
  - Gives a total order with -0 < +0; denormals ordered by magnitude.
- NaN:
  - Any lane input with exponent 8'hFF and mantissa != 0 forces the lane result to 16'h7FC0 and sets out_nan[i].
  - ±Inf are ordinary values.
- Elementwise modes (control 0x):
  - Latency 1 cycle: the beat accepted on edge k appears with out_valid=1 after edge k.
  - Ties return a. out_idx = 0, out_ovf = 0. in_last is ignored.
- Reduce modes (control 1x), FSM IDLE/RUN:
  - IDLE, accepted beat, in_last=0: load accumulator = a, idx = 0, cnt = 1, latch mode; go to RUN.
  - IDLE, accepted beat, in_last=1: single-beat packet; emit a, idx 0 with 1-cycle latency; stay IDLE.
  - RUN, accepted beat: replace a lane's accumulator only if strictly better (MAX: key greater; MIN: key less). Ties keep the earlier index; idx takes the current cnt when replacing.
  - RUN, accepted beat with in_last=1: fold that beat in, register the result, out_valid=1 next cycle, return to IDLE.
  - NaN in reduce: out_nan[i] becomes sticky; the lane accumulator becomes 7FC0 with idx = first NaN beat, and later beats do not replace it.
  - Mode is latched at the first beat. Changes to control while in RUN are ignored until the packet closes.
  - No output is produced on non-last beats, but in_ready still follows the handshake rule.
- Beat counter:
  - Saturates at 2^IDX_W-1.
  - A beat accepted while saturated sets out_ovf for that packet; indices of later winners are clamped to 2^IDX_W-1.
- Simultaneous events:
  - Output handshake and a new input beat in the same cycle: new result is loaded, out_valid stays 1.
  - Last beat accepted while the previous result drains in the same cycle: legal.

Decomposition:
- Package bf16_pkg holds:
  - typedef bf16_t (logic [15:0]);
  - BF16_QNAN = 16'h7FC0;
  - enum op_e {OP_EMIN, OP_EMAX, OP_RMAX, OP_RMIN};
  - function bf16_key(bf16_t) returning the 16-bit ordering key.
- One combinational sub-module, bf16_minmax_lane: inputs x, y, is_max; outputs sel_y (y strictly better), res, nan. Instantiated N times via generate. The FSM, beat counter and output register live in the top.

Test Plan:
- Elem MAX, N=2:
  - a1={4000,BF80}, b1={3F80,8000} -> out={4000,8000} one cycle after accept.
  - Elem MIN, a1=0000, b1=8000 -> 8000 (-0 < +0).
- Reduce MAX, lane0 stream 3F80, 4040, 4000, 4040 (last) -> out=4040, out_idx=1 (tie keeps earlier), busy high from beat 0 until the result registers.
- NaN: reduce MIN, lane1 stream 3F80, 7FC1, BF80 (last) -> lane1 out=7FC0, out_nan[1]=1, idx=1; lane0 unaffected.
- Backpressure: out_ready=0 with a result pending -> in_ready=0, out stable for 5 cycles; raising out_ready drains the result and accepts the next beat in the same cycle.
- Overflow and reset:
  - IDX_W=2, 6-beat reduce -> out_ovf=1, indices clamped at 3.
  - Assert rst1 mid-packet -> out_valid=0 and busy=0 immediately; the next packet's result is independent of the aborted one.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared BF16 types, constants and ordering helpers for the min/max stream unit.
package bf16_pkg;

   typedef logic [15:0] bf16_t;

   localparam bf16_t BF16_QNAN = 16'h7FC0;

   typedef enum logic [1:0] {
      OP_EMIN = 2'b00,
      OP_EMAX = 2'b01,
      OP_RMAX = 2'b10,
      OP_RMIN = 2'b11
   } op_e;

   // Sign-magnitude to offset-binary: unsigned compare gives a total order with -0 < +0.
   function automatic logic [15:0] bf16_key(input bf16_t x);
      return x[15] ? ~x : (x | 16'h8000);
   endfunction

   function automatic logic bf16_is_nan(input bf16_t x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

endpackage

// File: rtl/bf16_minmax_lane.sv
// One-lane BF16 min/max: picks y only when strictly better than x, NaN on either input wins.
module bf16_minmax_lane
   import bf16_pkg::*;
(
   input  bf16_t x,
   input  bf16_t y,
   input  logic  is_max,
   output logic  sel_y,
   output bf16_t res,
   output logic  nan
);

   logic [15:0] kx;
   logic [15:0] ky;

   assign kx    = bf16_key(x);
   assign ky    = bf16_key(y);
   assign nan   = bf16_is_nan(x) || bf16_is_nan(y);
   assign sel_y = !nan && (is_max ? (ky > kx) : (ky < kx));
   assign res   = nan ? BF16_QNAN : (sel_y ? y : x);

endmodule

// File: rtl/bf16_vec_minmax_stream.sv
// N-lane BF16 streaming min/max: elementwise MIN/MAX or per-lane packet reduction with argmax/argmin index.
module bf16_vec_minmax_stream
   import bf16_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = 8
)(
   input  logic                 clk1,
   input  logic                 rst1,
   input  logic [16*N-1:0]      a1,
   input  logic [16*N-1:0]      b1,
   input  logic [1:0]           control,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [16*N-1:0]      out,
   output logic [IDX_W*N-1:0]   out_idx,
   output logic [N-1:0]         out_nan,
   output logic                 out_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam logic [IDX_W-1:0] CNT_MAX = '1;
   localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_reg;
   op_e              mode_reg;
   bf16_t            acc_reg    [N];
   logic [IDX_W-1:0] idx_reg    [N];
   logic [N-1:0]     accnan_reg;
   logic [IDX_W-1:0] cnt_reg;
   logic             sat_reg;
   logic             ovf_reg;

   op_e              op_cur;
   logic             running;
   logic             accept;
   logic             is_reduce;
   logic             is_max;
   logic             load_out;
   logic             beat_ovf;

   bf16_t            lane_x     [N];
   bf16_t            lane_y     [N];
   bf16_t            lane_res   [N];
   logic [IDX_W-1:0] lane_idx   [N];
   logic [N-1:0]     lane_sel;
   logic [N-1:0]     lane_nan;

   assign running   = (state_reg == RUN);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign op_cur    = running ? mode_reg : op_e'(control);
   assign is_reduce = op_cur[1];
   assign is_max    = (op_cur == OP_EMAX) || (op_cur == OP_RMAX);
   assign load_out  = accept && (!is_reduce || in_last);
   assign busy      = running;

   // The counter sticks at CNT_MAX; the beat that lands on CNT_MAX is still legal,
   // only a further beat (sat_reg already set) means the packet outgrew the index space.
   assign beat_ovf  = running && (cnt_reg == CNT_MAX) && sat_reg;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         // IDLE reduce feeds a against itself so a first-beat NaN is canonicalised.
         assign lane_x[gi] = running ? acc_reg[gi] : a1[16*gi +: 16];
         assign lane_y[gi] = is_reduce ? a1[16*gi +: 16] : b1[16*gi +: 16];

         bf16_minmax_lane u_lane (
            .x      (lane_x[gi]),
            .y      (lane_y[gi]),
            .is_max (is_max),
            .sel_y  (lane_sel[gi]),
            .res    (lane_res[gi]),
            .nan    (lane_nan[gi])
         );

         // A newly seen NaN also claims the index; once the accumulator is NaN nothing replaces it.
         assign lane_idx[gi] = !running ? '0 :
                               (lane_sel[gi] || (lane_nan[gi] && !accnan_reg[gi])) ? cnt_reg :
                               idx_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk1 or posedge rst1) begin
      if (rst1) begin
         state_reg  <= IDLE;
         mode_reg   <= OP_EMIN;
         cnt_reg    <= '0;
         sat_reg    <= 1'b0;
         ovf_reg    <= 1'b0;
         accnan_reg <= '0;
         out        <= '0;
         out_idx    <= '0;
         out_nan    <= '0;
         out_ovf    <= 1'b0;
         out_valid  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            acc_reg[i] <= '0;
            idx_reg[i] <= '0;
         end
      end else begin
         if (load_out) begin
            out_valid <= 1'b1;
            out_ovf   <= running && (ovf_reg || beat_ovf);
            for (int i = 0; i < N; i++) begin
               out[16*i +: 16]         <= lane_res[i];
               out_idx[IDX_W*i +: IDX_W] <= lane_idx[i];
               out_nan[i]              <= lane_nan[i];
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept && is_reduce) begin
            for (int i = 0; i < N; i++) begin
               acc_reg[i]    <= lane_res[i];
               idx_reg[i]    <= lane_idx[i];
               accnan_reg[i] <= lane_nan[i];
            end
            if (!running) begin
               cnt_reg  <= CNT_ONE;
               sat_reg  <= 1'b0;
               ovf_reg  <= 1'b0;
               mode_reg <= op_cur;
               if (!in_last) state_reg <= RUN;
            end else begin
               if (cnt_reg == CNT_MAX) sat_reg <= 1'b1;
               else                    cnt_reg <= cnt_reg + CNT_ONE;
               if (beat_ovf) ovf_reg <= 1'b1;
               if (in_last)  state_reg <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_bf16_vec_minmax_stream.sv
// Randomised + directed bench for bf16_vec_minmax_stream against a packet-level reference model.
module tb_bf16_vec_minmax_stream;

   localparam int N     = 2;
   localparam int IDX_W = 2;
   localparam int W     = 16*N;
   localparam int MAXI  = (1 << IDX_W) - 1;

   logic               clk1 = 1'b0;
   logic               rst1 = 1'b1;
   logic [W-1:0]       a1 = '0;
   logic [W-1:0]       b1 = '0;
   logic [1:0]         control = 2'b00;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic               out_ready = 1'b1;
   logic               in_ready;
   logic [W-1:0]       out;
   logic [IDX_W*N-1:0] out_idx;
   logic [N-1:0]       out_nan;
   logic               out_ovf;
   logic               out_valid;
   logic               busy;

   bf16_vec_minmax_stream #(.N(N), .IDX_W(IDX_W)) dut (
      .clk1      (clk1),
      .rst1      (rst1),
      .a1        (a1),
      .b1        (b1),
      .control   (control),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out       (out),
      .out_idx   (out_idx),
      .out_nan   (out_nan),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk1 = ~clk1;

   int checks = 0;
   int errors = 0;

   // Reference model state: single output slot plus the beats of the open packet.
   bit                 m_valid = 0;
   logic [W-1:0]       m_out = '0;
   logic [IDX_W*N-1:0] m_idx = '0;
   logic [N-1:0]       m_nan = '0;
   logic               m_ovf = 1'b0;
   bit                 m_open = 0;
   logic [1:0]         m_mode = 2'b00;
   logic [W-1:0]       pkt[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] key16(input logic [15:0] x);
      return x[15] ? ~x : (x | 16'h8000);
   endfunction

   function automatic bit isnan16(input logic [15:0] x);
      return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
   endfunction

   function automatic bit better(input logic [15:0] y, input logic [15:0] x, input bit mx);
      return mx ? (key16(y) > key16(x)) : (key16(y) < key16(x));
   endfunction

   task automatic model_elem(input logic [W-1:0] a, input logic [W-1:0] b, input bit mx);
      for (int i = 0; i < N; i++) begin
         logic [15:0] la, lb;
         la = a[16*i +: 16];
         lb = b[16*i +: 16];
         if (isnan16(la) || isnan16(lb)) begin
            m_out[16*i +: 16] = 16'h7FC0;
            m_nan[i] = 1'b1;
         end else begin
            m_out[16*i +: 16] = better(lb, la, mx) ? lb : la;
            m_nan[i] = 1'b0;
         end
      end
      m_idx   = '0;
      m_ovf   = 1'b0;
      m_valid = 1;
   endtask

   // Whole-packet evaluation: earliest extreme wins, any NaN wins at its first index.
   task automatic model_reduce(input bit mx);
      for (int i = 0; i < N; i++) begin
         int          first_nan;
         int          bi;
         logic [15:0] best, v;
         first_nan = -1;
         bi = 0;
         best = pkt[0][16*i +: 16];
         for (int k = 0; k < pkt.size(); k++) begin
            v = pkt[k][16*i +: 16];
            if (isnan16(v)) begin
               if (first_nan < 0) first_nan = k;
            end else if (k > 0 && better(v, best, mx)) begin
               best = v;
               bi = k;
            end
         end
         if (first_nan >= 0) begin
            m_out[16*i +: 16] = 16'h7FC0;
            m_nan[i] = 1'b1;
            bi = first_nan;
         end else begin
            m_out[16*i +: 16] = best;
            m_nan[i] = 1'b0;
         end
         if (bi > MAXI) bi = MAXI;
         m_idx[IDX_W*i +: IDX_W] = IDX_W'(bi);
      end
      m_ovf   = (pkt.size() > (1 << IDX_W));
      m_valid = 1;
      pkt.delete();
   endtask

   // Compare-then-advance on every falling edge.
   always @(negedge clk1) begin
      bit acc;
      if (rst1) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_out", out, 0);
         chk("rst_out_idx", out_idx, 0);
         chk("rst_out_nan", out_nan, 0);
         chk("rst_out_ovf", out_ovf, 0);
         m_valid = 0;
         m_open  = 0;
         pkt.delete();
      end else begin
         chk("in_ready", in_ready, (!m_valid || out_ready));
         chk("busy", busy, m_open);
         chk("out_valid", out_valid, m_valid);
         if (m_valid) begin
            chk("out", out, m_out);
            chk("out_idx", out_idx, m_idx);
            chk("out_nan", out_nan, m_nan);
            chk("out_ovf", out_ovf, m_ovf);
         end
         acc = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready) m_valid = 0;
         if (acc) begin
            if (m_open) begin
               pkt.push_back(a1);
               if (in_last) begin
                  model_reduce(m_mode == 2'b10);
                  m_open = 0;
               end
            end else if (!control[1]) begin
               model_elem(a1, b1, control == 2'b01);
            end else begin
               pkt.push_back(a1);
               m_mode = control;
               if (in_last) model_reduce(control == 2'b10);
               else         m_open = 1;
            end
         end
      end
   end

   task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] ctl, input logic last);
      int n;
      n = 0;
      a1 = a; b1 = b; control = ctl; in_last = last; in_valid = 1'b1;
      @(negedge clk1);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk1);
      end
      if (n >= 50) chk("beat_accept_timeout", in_ready, 1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   function automatic logic [15:0] rv();
      logic [15:0] tbl [12];
      int r;
      tbl = '{16'h0000, 16'h8000, 16'h3F80, 16'hBF80, 16'h4000, 16'hC000,
              16'h7F80, 16'hFF80, 16'h0001, 16'h8001, 16'h4040, 16'h3F80};
      r = $urandom_range(0, 31);
      if (r < 12)  return tbl[r];
      if (r == 12) return 16'h7FC1;
      if (r == 13) return 16'hFF81;
      return 16'($urandom);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      rst1 = 1'b0;
      idle(1);

      // Elementwise MAX: -0 beats -1, 2 beats 1.
      beat(32'h4000BF80, 32'h3F808000, 2'b01, 1'b0);
      chk("emax_valid", out_valid, 1);
      chk("emax_out", out, 32'h40008000);
      chk("emax_idx", out_idx, 0);
      idle(2);

      // Elementwise MIN: -0 < +0.
      beat(32'h00000000, 32'h80008000, 2'b00, 1'b0);
      chk("emin_out", out, 32'h80008000);
      idle(2);

      // Reduce MAX with a later tie; control changes mid-packet must be ignored.
      beat(32'h00003F80, 32'h0, 2'b10, 1'b0);
      chk("rmax_busy", busy, 1);
      chk("rmax_no_out", out_valid, 0);
      beat(32'h00004040, 32'h0, 2'b01, 1'b0);
      beat(32'h00004000, 32'h0, 2'b00, 1'b0);
      beat(32'h00004040, 32'h0, 2'b01, 1'b1);
      chk("rmax_valid", out_valid, 1);
      chk("rmax_busy_done", busy, 0);
      chk("rmax_out", out, 32'h00004040);
      chk("rmax_idx", out_idx, 4'b0001);
      idle(2);

      // Reduce MIN with a NaN in lane 1.
      beat(32'h3F804000, 32'h0, 2'b11, 1'b0);
      beat(32'h7FC13F80, 32'h0, 2'b11, 1'b0);
      beat(32'hBF804040, 32'h0, 2'b11, 1'b1);
      chk("rnan_out", out, 32'h7FC03F80);
      chk("rnan_nan", out_nan, 2'b10);
      chk("rnan_idx", out_idx, 4'b0101);
      idle(2);

      // Backpressure: held result blocks input, then drain and accept in one cycle.
      out_ready = 1'b0;
      beat(32'h3F803F80, 32'h0, 2'b01, 1'b0);
      a1 = 32'h40004000; b1 = 32'hC0000000; control = 2'b00; in_last = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_hold", out, 32'h3F803F80);
         @(posedge clk1); #1;
      end
      out_ready = 1'b1;
      @(negedge clk1);
      chk("bp_in_ready_up", in_ready, 1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
      chk("bp_valid", out_valid, 1);
      chk("bp_out_new", out, 32'hC0000000);
      idle(2);

      // Six-beat reduce with only four index values: overflow and clamping.
      beat(32'h00003F80, 32'h0, 2'b10, 1'b0);
      beat(32'h00004000, 32'h0, 2'b10, 1'b0);
      beat(32'h00004040, 32'h0, 2'b10, 1'b0);
      beat(32'h00004080, 32'h0, 2'b10, 1'b0);
      beat(32'h000040A0, 32'h0, 2'b10, 1'b0);
      beat(32'h000040C0, 32'h0, 2'b10, 1'b1);
      chk("ovf_out", out, 32'h000040C0);
      chk("ovf_idx", out_idx, 4'b0011);
      chk("ovf_flag", out_ovf, 1);
      idle(2);

      // Reset mid-packet, then an independent packet.
      beat(32'h00007F80, 32'h0, 2'b10, 1'b0);
      beat(32'h00003F80, 32'h0, 2'b10, 1'b0);
      rst1 = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk1);
      @(posedge clk1); #1;
      rst1 = 1'b0;
      beat(32'h00003F80, 32'h0, 2'b10, 1'b0);
      beat(32'h00004000, 32'h0, 2'b10, 1'b1);
      chk("post_rst_out", out, 32'h00004000);
      chk("post_rst_idx", out_idx, 4'b0001);
      chk("post_rst_ovf", out_ovf, 0);
      idle(2);

      // Random traffic, including mid-packet control changes and output stalls.
      repeat (1500) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         control   = 2'($urandom_range(0, 3));
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            a1[16*i +: 16] = rv();
            b1[16*i +: 16] = rv();
         end
         @(posedge clk1); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
